// File: rtl/mem_arbiter.sv
// mem_arbiter: lets CHANNELS cache-side requesters share one memory port, one transaction at a time.
// Round-robin grant by default; define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (channel 0 highest).
module mem_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2*CHANNELS-1:0]          ch_rw_flag,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_wdata,
    input  logic [CHANNELS*MASK_WIDTH-1:0] ch_mask,
    output logic [CHANNELS-1:0]            ch_done,
    output logic [DATA_WIDTH-1:0]          ch_rdata,
    input  logic                           mem_free,
    input  logic                           mem_read_valid,
    input  logic [DATA_WIDTH-1:0]          mem_i_data,
    output logic [1:0]                     mem_rw_flag,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_o_data,
    output logic [MASK_WIDTH-1:0]          mem_o_mask
);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [1:0] FLAG_READ  = 2'b01;
    localparam logic [1:0] FLAG_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_flag;
    logic [IW-1:0]         r_idx;
    logic                  r_wait_first;
    logic [CHANNELS-1:0]   r_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [MASK_WIDTH-1:0] r_mask;

    logic [CHANNELS-1:0]   w_valid;
    logic [IW-1:0]         w_base;
    logic [IW-1:0]         w_win;
    logic [IW-1:0]         w_cand_idx;
    logic                  w_found;
    logic                  w_hit;
    int                    w_cand;
    logic [1:0]            w_mem_rw_flag;
    logic                  w_grant;
    logic                  w_resp_entry;

    function automatic logic [CHANNELS-1:0] onehot(input logic [IW-1:0] idx);
        logic [CHANNELS-1:0] v;
        v = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            v[i] = (idx == IW'(i));
        end
        return v;
    endfunction

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign w_base = '0;
`else
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_next;
    assign w_base     = r_ptr;
    assign w_ptr_next = (w_win == IW'(CHANNELS - 1)) ? '0 : (w_win + 1'b1);
`endif

    // Decode which channels carry a read or write (00 and 11 count as idle)
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_valid[i] = (ch_rw_flag[2*i +: 2] == FLAG_READ) || (ch_rw_flag[2*i +: 2] == FLAG_WRITE);
        end
    end

    // First valid channel found scanning upward from w_base, wrapping at CHANNELS
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        w_hit      = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_cand     = int'(w_base) + k;
            w_cand     = (w_cand >= CHANNELS) ? (w_cand - CHANNELS) : w_cand;
            w_cand_idx = IW'(w_cand);
            w_hit      = !w_found && w_valid[w_cand_idx];
            w_win      = w_hit ? w_cand_idx : w_win;
            w_found    = w_found || w_hit;
        end
    end

    // Next-state and memory command decode
    always_comb begin
        w_state_next  = r_state;
        w_mem_rw_flag = 2'b00;
        case (r_state)
            S_IDLE: begin
                w_state_next = w_found ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                if (mem_free) begin
                    w_state_next  = S_WAIT;
                    w_mem_rw_flag = r_flag;
                end else begin
                    w_state_next  = S_ISSUE;
                    w_mem_rw_flag = 2'b00;
                end
            end
            S_WAIT: begin
                // a write completes on mem_free, but the first WAIT cycle's mem_free still reflects the command slot
                if (r_flag == FLAG_READ) begin
                    w_state_next = mem_read_valid ? S_RESP : S_WAIT;
                end else begin
                    w_state_next = (mem_free && !r_wait_first) ? S_RESP : S_WAIT;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_grant      = (r_state == S_IDLE) && w_found;
    assign w_resp_entry = (r_state == S_WAIT) && (w_state_next == S_RESP);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the winner's command fields at grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag  <= 2'b00;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
        end else if (w_grant) begin
            r_flag  <= ch_rw_flag[2*w_win +: 2];
            r_idx   <= w_win;
            r_addr  <= ch_addr[ADDR_WIDTH*w_win +: ADDR_WIDTH];
            r_wdata <= ch_wdata[DATA_WIDTH*w_win +: DATA_WIDTH];
            r_mask  <= ch_mask[MASK_WIDTH*w_win +: MASK_WIDTH];
        end
    end

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    // Round-robin pointer: channel after the last winner gets top priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    // Completion pulse, read data capture and first-WAIT-cycle marker
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done       <= '0;
            r_rdata      <= '0;
            r_wait_first <= 1'b0;
        end else begin
            r_wait_first <= (r_state == S_ISSUE);
            r_done       <= w_resp_entry ? onehot(r_idx) : '0;
            if (w_resp_entry && (r_flag == FLAG_READ)) begin
                r_rdata <= mem_i_data;
            end
        end
    end

    assign ch_done     = r_done;
    assign ch_rdata    = r_rdata;
    assign mem_rw_flag = w_mem_rw_flag;
    assign mem_addr    = r_addr;
    assign mem_o_data  = r_wdata;
    assign mem_o_mask  = r_mask;

endmodule
